multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter RETIRE_W, default 32: width of the retired-instruction counter.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high; forces the block to its reset state immediately.
REQ-004 Opcode  input  7  opcode field of the instruction register contents.
REQ-005 imem_ready  input  1  instruction memory has valid data this cycle.
REQ-006 dmem_ready  input  1  data memory access completes this cycle.
REQ-007 IMemRead  output  1  instruction fetch request.
REQ-008 IRWrite  output  1  load instruction register.
REQ-009 PCWrite  output  1  update PC.
REQ-010 Branch, JalrSel  output  1 each  PC source selects.
REQ-011 ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite  output  1 each  datapath controls.
REQ-012 ALUOp  output  2  ALU operation class; WRMux  output  2  register write-data select.
REQ-013 Halted  output  1  halt reached; Illegal  output  1  sticky illegal-opcode flag.
REQ-014 state  output  3  current FSM state; retired  output  RETIRE_W  count of retired instructions.

Function
REQ-015 Opcodes: R 0110011, I 0010011, U 0110111, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, HALT 1111111; any other opcode is illegal.
REQ-016 States and encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5; encodings 6 and 7 go to FETCH on the next edge.
REQ-017 FETCH: IMemRead=1; stay while imem_ready=0; when imem_ready=1, IRWrite=1 for that cycle and go to DECODE.
REQ-018 DECODE: Opcode is captured into internal op_q; next state is HALT for HALT and EXEC for legal opcodes.
REQ-019 DECODE with an illegal opcode: PCWrite=1 (treated as NOP, retired), Illegal is set, next state FETCH.
REQ-020 EXEC: for BRANCH, Branch=1 and PCWrite=1, next state FETCH; for LOAD/STORE, next state MEM; for all other legal opcodes, next state WB.
REQ-021 MEM: MemRead=1 (LOAD) or MemWrite=1 (STORE), held while dmem_ready=0; on dmem_ready=1, LOAD goes to WB; STORE asserts PCWrite=1 and goes to FETCH.
REQ-022 WB: RegWrite=1 and PCWrite=1; Branch=1 for JAL; JalrSel=1 for JALR; MemtoReg=1 for LOAD; next state FETCH.
REQ-023 Decoded from op_q and driven only in EXEC, MEM and WB (0 in all other states): ALUSrc=1 for LOAD/STORE/I/JALR/U.
REQ-024 ALUOp encoding: R/I=10, BRANCH=01, JAL/U=11, LOAD/STORE/JALR=00.
REQ-025 WRMux encoding: JAL/JALR=01, U=10, otherwise 00.
REQ-026 All strobes (IMemRead, IRWrite, PCWrite, RegWrite, MemRead, MemWrite, Branch, JalrSel) are 0 in any state/condition not listed above.
REQ-027 Outputs are Moore/Mealy combinational decodes of state, op_q, imem_ready and dmem_ready; no output lags the state by a cycle.
REQ-028 retired increments by 1 on every cycle with PCWrite=1, wrapping from 2^RETIRE_W-1 to 0.
REQ-029 HALT: Halted=1, all strobes 0, the state is held until reset, and Opcode and the ready inputs are ignored.
REQ-030 Minimum latencies with ready inputs tied high: BRANCH 3 cycles, R/I/U/JAL/JALR/STORE 4 cycles, LOAD 5 cycles, illegal 2 cycles.
REQ-031 A ready input asserted in a state that does not wait on it has no effect.

Reset
REQ-032 On reset assertion, the block immediately enters FETCH with op_q=0, retired=0, Illegal=0 and Halted=0, including mid-instruction and from HALT.
REQ-033 On reset deassertion, the first rising edge evaluates FETCH normally; with imem_ready high, IRWrite pulses in the first cycle.

Verification
REQ-034 R-type with ready inputs high -> state sequence 0,1,2,4,0; RegWrite and PCWrite high only in WB; ALUOp=10; retired=1.
REQ-035 LOAD with dmem_ready low for 3 MEM cycles -> MemRead high for 4 cycles; then WB with MemtoReg=1 and RegWrite=1; instruction takes 8 cycles total.
REQ-036 BRANCH then JAL -> Branch=1 with PCWrite=1 in BRANCH's EXEC; JAL WB shows Branch=1, WRMux=01, ALUOp=11; retired=2.
REQ-037 Opcode 0000000 -> Illegal=1, PCWrite pulse in DECODE, back to FETCH; retired=1.
REQ-038 Opcode HALT -> Halted=1 and state=5 held for 20 cycles with all strobes 0; reset asserted -> state=0 and Halted=0 immediately.
REQ-039 RETIRE_W=4, run 17 R-type instructions -> retired wraps to 1; reset asserted during MEM -> MemWrite drops without a clock edge and state=0.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V style control unit.
// Sequences FETCH/DECODE/EXEC/MEM/WB per instruction, decodes datapath
// controls from the latched opcode and counts retired instructions.
// Handshake: imem_ready/dmem_ready are sampled only in the state that waits
// on them (FETCH and MEM); the strobe for that access stays high until the
// cycle in which the ready input is seen high, and the FSM advances on that
// same rising edge.
module multicycle_controller #(
  parameter int RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [6:0]          Opcode,
  input  logic                imem_ready,
  input  logic                dmem_ready,
  output logic                IMemRead,
  output logic                IRWrite,
  output logic                PCWrite,
  output logic                Branch,
  output logic                JalrSel,
  output logic                ALUSrc,
  output logic                MemtoReg,
  output logic                RegWrite,
  output logic                MemRead,
  output logic                MemWrite,
  output logic [1:0]          ALUOp,
  output logic [1:0]          WRMux,
  output logic                Halted,
  output logic                Illegal,
  output logic [2:0]          state,
  output logic [RETIRE_W-1:0] retired
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_U      = 7'b0110111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_HALT   = 7'b1111111;

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  logic [2:0]          r_state;
  logic [2:0]          w_next_state;
  logic [6:0]          r_op_q;
  logic [RETIRE_W-1:0] r_retired;
  logic                r_illegal;

  // Classification of the live Opcode input, used only while in DECODE.
  logic w_dec_halt;
  logic w_dec_legal;
  assign w_dec_halt  = (Opcode == OP_HALT);
  assign w_dec_legal = (Opcode == OP_R)      || (Opcode == OP_I)     ||
                       (Opcode == OP_U)      || (Opcode == OP_LOAD)  ||
                       (Opcode == OP_STORE)  || (Opcode == OP_BRANCH) ||
                       (Opcode == OP_JAL)    || (Opcode == OP_JALR);

  // Classification of the latched opcode, used from EXEC onwards.
  logic w_op_r, w_op_i, w_op_u, w_op_load, w_op_store;
  logic w_op_branch, w_op_jal, w_op_jalr;
  assign w_op_r      = (r_op_q == OP_R);
  assign w_op_i      = (r_op_q == OP_I);
  assign w_op_u      = (r_op_q == OP_U);
  assign w_op_load   = (r_op_q == OP_LOAD);
  assign w_op_store  = (r_op_q == OP_STORE);
  assign w_op_branch = (r_op_q == OP_BRANCH);
  assign w_op_jal    = (r_op_q == OP_JAL);
  assign w_op_jalr   = (r_op_q == OP_JALR);

  // Datapath decodes are only meaningful once the opcode has been latched.
  logic w_exec_phase;
  assign w_exec_phase = (r_state == S_EXEC) || (r_state == S_MEM) ||
                        (r_state == S_WB);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next_state;
  end

  // Opcode latch, retire counter and sticky illegal flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op_q    <= 7'd0;
      r_retired <= '0;
      r_illegal <= 1'b0;
    end else begin
      if (r_state == S_DECODE) r_op_q <= Opcode;
      if (PCWrite) r_retired <= r_retired + 1'b1;
      if ((r_state == S_DECODE) && !w_dec_legal && !w_dec_halt)
        r_illegal <= 1'b1;
    end
  end

  // Next-state selection.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_FETCH:  if (imem_ready) w_next_state = S_DECODE;
      S_DECODE: begin
        if (w_dec_halt)       w_next_state = S_HALT;
        else if (w_dec_legal) w_next_state = S_EXEC;
        else                  w_next_state = S_FETCH;
      end
      S_EXEC: begin
        if (w_op_branch)                  w_next_state = S_FETCH;
        else if (w_op_load || w_op_store) w_next_state = S_MEM;
        else                              w_next_state = S_WB;
      end
      S_MEM: begin
        if (dmem_ready) w_next_state = w_op_load ? S_WB : S_FETCH;
      end
      S_WB:     w_next_state = S_FETCH;
      S_HALT:   w_next_state = S_HALT;
      default:  w_next_state = S_FETCH;
    endcase
  end

  // Output decode from state, latched opcode and ready inputs.
  always_comb begin
    IMemRead = 1'b0;
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    Branch   = 1'b0;
    JalrSel  = 1'b0;
    MemtoReg = 1'b0;
    RegWrite = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    ALUSrc   = 1'b0;
    ALUOp    = 2'b00;
    WRMux    = 2'b00;
    case (r_state)
      S_FETCH: begin
        IMemRead = 1'b1;
        IRWrite  = imem_ready;
      end
      S_DECODE: PCWrite = !w_dec_legal && !w_dec_halt;
      S_EXEC: begin
        Branch  = w_op_branch;
        PCWrite = w_op_branch;
      end
      S_MEM: begin
        MemRead  = w_op_load;
        MemWrite = w_op_store;
        PCWrite  = w_op_store && dmem_ready;
      end
      S_WB: begin
        RegWrite = 1'b1;
        PCWrite  = 1'b1;
        Branch   = w_op_jal;
        JalrSel  = w_op_jalr;
        MemtoReg = w_op_load;
      end
      default: ;
    endcase
    if (w_exec_phase) begin
      ALUSrc = w_op_load || w_op_store || w_op_i || w_op_jalr || w_op_u;
      if (w_op_r || w_op_i)        ALUOp = 2'b10;
      else if (w_op_branch)        ALUOp = 2'b01;
      else if (w_op_jal || w_op_u) ALUOp = 2'b11;
      else                         ALUOp = 2'b00;
      if (w_op_jal || w_op_jalr)   WRMux = 2'b01;
      else if (w_op_u)             WRMux = 2'b10;
      else                         WRMux = 2'b00;
    end
  end

  assign Halted  = (r_state == S_HALT);
  assign Illegal = r_illegal;
  assign state   = r_state;
  assign retired = r_retired;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller. A second instance with a 4-bit
// retire counter shares all inputs to observe counter wrap-around.
module tb_multicycle_controller;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_U      = 7'b0110111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_HALT   = 7'b1111111;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] Opcode = 7'd0;
  logic       imem_ready = 1'b0;
  logic       dmem_ready = 1'b0;

  logic        IMemRead, IRWrite, PCWrite, Branch, JalrSel, ALUSrc;
  logic        MemtoReg, RegWrite, MemRead, MemWrite, Halted, Illegal;
  logic [1:0]  ALUOp, WRMux;
  logic [2:0]  state;
  logic [31:0] retired;

  logic        d4_IMemRead, d4_IRWrite, d4_PCWrite, d4_Branch, d4_JalrSel;
  logic        d4_ALUSrc, d4_MemtoReg, d4_RegWrite, d4_MemRead, d4_MemWrite;
  logic        d4_Halted, d4_Illegal;
  logic [1:0]  d4_ALUOp, d4_WRMux;
  logic [2:0]  d4_state;
  logic [3:0]  d4_retired;

  int errors = 0;
  int checks = 0;

  multicycle_controller #(.RETIRE_W(32)) dut (
    .clk(clk), .reset(reset), .Opcode(Opcode),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .IMemRead(IMemRead), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .Branch(Branch), .JalrSel(JalrSel), .ALUSrc(ALUSrc),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .MemRead(MemRead),
    .MemWrite(MemWrite), .ALUOp(ALUOp), .WRMux(WRMux),
    .Halted(Halted), .Illegal(Illegal), .state(state), .retired(retired)
  );

  multicycle_controller #(.RETIRE_W(4)) dut4 (
    .clk(clk), .reset(reset), .Opcode(Opcode),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .IMemRead(d4_IMemRead), .IRWrite(d4_IRWrite), .PCWrite(d4_PCWrite),
    .Branch(d4_Branch), .JalrSel(d4_JalrSel), .ALUSrc(d4_ALUSrc),
    .MemtoReg(d4_MemtoReg), .RegWrite(d4_RegWrite), .MemRead(d4_MemRead),
    .MemWrite(d4_MemWrite), .ALUOp(d4_ALUOp), .WRMux(d4_WRMux),
    .Halted(d4_Halted), .Illegal(d4_Illegal), .state(d4_state),
    .retired(d4_retired)
  );

  // Clock generation: 10 time-unit period.
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    imem_ready = 1'b1;
    dmem_ready = 1'b0;
    Opcode     = OP_R;
    reset      = 1'b1;
    #1;
    checks++;
    if (state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
    checks++;
    if (retired !== 32'd0) begin errors++; $display("FAIL reset_retired: got %0d expected 0", retired); end
    checks++;
    if ({Illegal, Halted} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b expected 00", {Illegal, Halted}); end
    reset = 1'b0;
    #1;
    checks++;
    if ({IMemRead, IRWrite} !== 2'b11) begin errors++; $display("FAIL reset_first_fetch: got %b expected 11", {IMemRead, IRWrite}); end
    step();
    checks++;
    if (state !== 3'd1) begin errors++; $display("FAIL reset_to_decode: got %0d expected 1", state); end
  endtask

  task automatic test_rtype();
    logic [2:0] exp_st [4] = '{3'd0, 3'd1, 3'd2, 3'd4};
    do_reset();
    Opcode = OP_R; imem_ready = 1'b1; dmem_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if (state !== exp_st[c]) begin errors++; $display("FAIL rtype_state c%0d: got %0d expected %0d", c, state, exp_st[c]); end
      checks++;
      if ({RegWrite, PCWrite} !== ((c == 3) ? 2'b11 : 2'b00)) begin errors++; $display("FAIL rtype_wr c%0d: got %b", c, {RegWrite, PCWrite}); end
      if (c >= 2) begin
        checks++;
        if (ALUOp !== 2'b10) begin errors++; $display("FAIL rtype_aluop c%0d: got %b expected 10", c, ALUOp); end
      end
      step();
    end
    checks++;
    if (state !== 3'd0) begin errors++; $display("FAIL rtype_end_state: got %0d expected 0", state); end
    checks++;
    if (retired !== 32'd1) begin errors++; $display("FAIL rtype_retired: got %0d expected 1", retired); end
  endtask

  task automatic test_load_wait();
    logic [2:0] exp_st [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd4};
    int mr_cycles = 0;
    do_reset();
    Opcode = OP_LOAD; imem_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      dmem_ready = (c == 6);
      #1;
      checks++;
      if (state !== exp_st[c]) begin errors++; $display("FAIL load_state c%0d: got %0d expected %0d", c, state, exp_st[c]); end
      if (MemRead === 1'b1) mr_cycles++;
      if (c == 7) begin
        checks++;
        if ({MemtoReg, RegWrite, PCWrite} !== 3'b111) begin errors++; $display("FAIL load_wb: got %b expected 111", {MemtoReg, RegWrite, PCWrite}); end
      end
      step();
    end
    checks++;
    if (mr_cycles != 4) begin errors++; $display("FAIL load_memread_cycles: got %0d expected 4", mr_cycles); end
    checks++;
    if (state !== 3'd0) begin errors++; $display("FAIL load_end_state: got %0d expected 0", state); end
    checks++;
    if (retired !== 32'd1) begin errors++; $display("FAIL load_retired: got %0d expected 1", retired); end
  endtask

  task automatic test_branch_jal();
    do_reset();
    Opcode = OP_BRANCH; imem_ready = 1'b1; dmem_ready = 1'b1;
    step(); step();
    #1;
    checks++;
    if ({state, Branch, PCWrite, ALUOp} !== {3'd2, 1'b1, 1'b1, 2'b01}) begin errors++; $display("FAIL branch_exec: got %b expected 0101101", {state, Branch, PCWrite, ALUOp}); end
    step();
    Opcode = OP_JAL;
    #1;
    checks++;
    if (state !== 3'd0) begin errors++; $display("FAIL branch_latency: got %0d expected 0", state); end
    step(); step(); step();
    #1;
    checks++;
    if ({state, Branch, PCWrite, RegWrite} !== {3'd4, 3'b111}) begin errors++; $display("FAIL jal_wb_strobes: got %b expected 100111", {state, Branch, PCWrite, RegWrite}); end
    checks++;
    if ({WRMux, ALUOp} !== 4'b0111) begin errors++; $display("FAIL jal_wb_mux: got %b expected 0111", {WRMux, ALUOp}); end
    step();
    checks++;
    if (retired !== 32'd2) begin errors++; $display("FAIL branch_jal_retired: got %0d expected 2", retired); end
  endtask

  task automatic test_illegal();
    do_reset();
    Opcode = 7'b0000000; imem_ready = 1'b1; dmem_ready = 1'b1;
    step();
    #1;
    checks++;
    if ({state, PCWrite, Illegal} !== {3'd1, 1'b1, 1'b0}) begin errors++; $display("FAIL illegal_decode: got %b expected 00110", {state, PCWrite, Illegal}); end
    step();
    checks++;
    if ({state, Illegal} !== {3'd0, 1'b1}) begin errors++; $display("FAIL illegal_flag: got %b expected 0001", {state, Illegal}); end
    checks++;
    if (retired !== 32'd1) begin errors++; $display("FAIL illegal_retired: got %0d expected 1", retired); end
    Opcode = OP_R;
    repeat (4) step();
    checks++;
    if ({Illegal, retired} !== {1'b1, 32'd2}) begin errors++; $display("FAIL illegal_sticky: got %0h expected 100000002", {Illegal, retired}); end
  endtask

  task automatic test_halt();
    do_reset();
    Opcode = OP_HALT; imem_ready = 1'b1; dmem_ready = 1'b1;
    step(); step();
    for (int c = 0; c < 20; c++) begin
      Opcode     = 7'($urandom_range(0, 127));
      imem_ready = 1'($urandom_range(0, 1));
      dmem_ready = 1'($urandom_range(0, 1));
      #1;
      checks++;
      if ({state, Halted} !== {3'd5, 1'b1}) begin errors++; $display("FAIL halt_hold c%0d: got %b expected 1011", c, {state, Halted}); end
      checks++;
      if ({IMemRead, IRWrite, PCWrite, RegWrite, MemRead, MemWrite, Branch, JalrSel} !== 8'd0) begin errors++; $display("FAIL halt_strobes c%0d: got %b expected 0", c, {IMemRead, IRWrite, PCWrite, RegWrite, MemRead, MemWrite, Branch, JalrSel}); end
      step();
    end
    checks++;
    if (retired !== 32'd0) begin errors++; $display("FAIL halt_retired: got %0d expected 0", retired); end
    reset = 1'b1;
    #1;
    checks++;
    if ({state, Halted} !== {3'd0, 1'b0}) begin errors++; $display("FAIL halt_async_reset: got %b expected 0000", {state, Halted}); end
    reset = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [6:0] ops  [4] = '{OP_JALR, OP_U, OP_I, OP_STORE};
    logic [9:0] vecs [4] = '{10'b1100110001, 10'b1100011110, 10'b1100011000, 10'b0110010000};
    do_reset();
    imem_ready = 1'b1; dmem_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      Opcode = ops[k];
      #1;
      checks++;
      if ({state, IRWrite} !== {3'd0, 1'b1}) begin errors++; $display("FAIL b2b_fetch op%0d: got %b expected 0001", k, {state, IRWrite}); end
      step(); step();
      #1;
      checks++;
      if ({state, ALUSrc} !== {3'd2, 1'b1}) begin errors++; $display("FAIL b2b_exec op%0d: got %b expected 0101", k, {state, ALUSrc}); end
      step();
      #1;
      checks++;
      if ({RegWrite, PCWrite, MemWrite, Branch, JalrSel, ALUSrc, ALUOp, WRMux} !== vecs[k]) begin errors++; $display("FAIL b2b_final op%0d: got %b expected %b", k, {RegWrite, PCWrite, MemWrite, Branch, JalrSel, ALUSrc, ALUOp, WRMux}, vecs[k]); end
      step();
    end
    checks++;
    if ({state, retired} !== {3'd0, 32'd4}) begin errors++; $display("FAIL b2b_retired: got %0h expected 4", {state, retired}); end
  endtask

  task automatic test_wrap();
    do_reset();
    Opcode = OP_R; imem_ready = 1'b1; dmem_ready = 1'b1;
    repeat (68) step();
    checks++;
    if (d4_retired !== 4'd1) begin errors++; $display("FAIL wrap_retired4: got %0d expected 1", d4_retired); end
    checks++;
    if (retired !== 32'd17) begin errors++; $display("FAIL wrap_retired32: got %0d expected 17", retired); end
  endtask

  task automatic test_reset_in_mem();
    do_reset();
    Opcode = OP_STORE; imem_ready = 1'b1; dmem_ready = 1'b0;
    step(); step(); step();
    #1;
    checks++;
    if ({state, MemWrite} !== {3'd3, 1'b1}) begin errors++; $display("FAIL mem_wait: got %b expected 0111", {state, MemWrite}); end
    reset = 1'b1;
    #1;
    checks++;
    if ({state, MemWrite} !== {3'd0, 1'b0}) begin errors++; $display("FAIL mem_async_reset: got %b expected 0000", {state, MemWrite}); end
    reset = 1'b0;
  endtask

  initial begin
    step();
    test_reset();
    test_rtype();
    test_load_wait();
    test_branch_jal();
    test_illegal();
    test_halt();
    test_back_to_back();
    test_wrap();
    test_reset_in_mem();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
